calc_input_parser: RTL and testbench
====================================

// Module: calc_input_parser
// PURPOSE
//  Consumes bytes from the UART receiver (data_out/received) and parses ASCII keystrokes into a calculator command.
//  Command form: BCD operand A, operator, BCD operand B.
//  Enter (0x0D) emits a one-cycle cmd_valid pulse to the downstream ALU.
//  Also drives the operand currently being typed to the 7-seg display path.
// PARAMETERS
//  DIGITS  4            max decimal digits per operand
//  OPW     4*DIGITS     operand width, packed BCD (digit 0 in [3:0])
// PORTS
//  clk          in   1    system clock; single clock domain
//  reset        in   1    synchronous, active-high
//  rx_data      in   8    byte from receiver; stable while rx_received high
//  rx_received  in   1    receiver "byte ready" level, baud domain; new byte = rising edge
//  operand_a    out  OPW  BCD operand A
//  operand_b    out  OPW  BCD operand B
//  op_code      out  2    00 '+', 01 '-', 10 '*', 11 '/'
//  cmd_valid    out  1    1-cycle pulse: operands/op_code complete and held
//  err          out  1    1-cycle pulse: rejected keystroke
//  cur_display  out  OPW  ENTER_A: operand_a; ENTER_B/SHOW: operand_b
// BEHAVIOUR
//  Reset:
//  - All outputs 0, digit counts 0, state ENTER_A.
//  - Sync and edge flops reset to 1, so a high rx_received at reset release gives no spurious byte.
//  Input:
//  - rx_received passes a 2-FF synchronizer, then rising-edge detect.
//  - rx_data is sampled in the edge-detect cycle.
//  - The FSM acts on the byte in the next cycle.
//  - Pin edge to cmd_valid/err = 4 clk.
//  - Edges that arrive faster than 1 per 2 clk are not required to be caught (baud is far slower).
//  Char classes:
//  - DIGIT 0x30-0x39
//  - OP '+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F
//  - ENTER 0x0D
//  - CLR 'C'/'c'/0x1B
//  - Any other byte is ignored: no err, no state change.
//  Digit insertion: operand <= {operand[OPW-5:0], digit}; count++.
//  - If count==DIGITS: err pulse, operand unchanged.
//  ENTER_A:
//  - DIGIT: insert into A.
//  - OP: count_a==0 -> err; else latch op_code, go to ENTER_B.
//  - ENTER: err, stay.
//  ENTER_B:
//  - DIGIT: insert into B.
//  - OP: count_b==0 -> replace op_code (latest wins); else err.
//  - ENTER: count_b==0 -> err; else cmd_valid pulse, go to SHOW.
//  SHOW: operands/op_code held for the ALU.
//  - DIGIT: clear A/B/counts, insert digit into A, go to ENTER_A.
//  - OP/ENTER: err, stay.
//  CLR in any state: A=B=0, counts=0, op_code=00, go to ENTER_A, no err.
//  cmd_valid and err are never asserted in the same cycle.
//  Reset mid-entry: everything discarded; a byte whose edge is still in the synchronizer is dropped.
// CONFIGURATION
//  CALC_BACKSPACE_EN defined: BS 0x08/0x7F in ENTER_A/ENTER_B:
//  - Removes last digit: operand >> 4, count--.
//  - ENTER_B with count_b==0: op_code=00, go to ENTER_A (A intact).
//  - ENTER_A with count_a==0: ignored.
//  - SHOW: ignored.
//  CALC_BACKSPACE_EN undefined: BS bytes fall into "other", ignored.
// STRUCTURE
//  Package calc_pkg:
//  - op_code localparams OP_ADD/OP_SUB/OP_MUL/OP_DIV
//  - ASCII constants
//  - state encoding ENTER_A/ENTER_B/SHOW
//  - shared with the ALU and display blocks
//  Sub-module rx_byte_strobe: 2-FF sync + edge detect + data capture; outputs byte_stb, byte.
// TESTING
//  Reset sequence:
//  - "12+34\r" -> operand_a=0x0012, op_code=00, operand_b=0x0034.
//  - Exactly one cmd_valid pulse, 4 clk after the '\r' edge; no err.
//  "12345" -> operand_a=0x1234; err pulse on '5' only.
//  Rejected keys:
//  - "+" first -> err, stays ENTER_A.
//  - "7*\r" -> err on '\r', no cmd_valid.
//  - "7*-2\r" -> op_code=01.
//  After SHOW:
//  - '9' -> A=0x0009, B=0, cur_display=0x0009.
//  - 'c' mid-entry -> all zero, ENTER_A.
//  Reset / edge checks:
//  - rx_received held high through reset release -> no byte processed.
//  - Reset asserted 1 clk after an edge -> no output pulse.
//  With CALC_BACKSPACE_EN: "56\b" -> A=0x0005; "5+\b" -> ENTER_A, op_code=00.
//  Without it: "56\b" -> A=0x0056.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: op codes, ASCII key constants, parser state encoding
// and the keystroke classifier used by the input parser, ALU and display blocks.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_UC_C  = 8'h43;
    localparam logic [7:0] ASCII_LC_C  = 8'h63;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    localparam logic [1:0] ST_ENTER_A = 2'd0;
    localparam logic [1:0] ST_ENTER_B = 2'd1;
    localparam logic [1:0] ST_SHOW    = 2'd2;

    typedef enum logic [2:0] {
        CC_OTHER,
        CC_DIGIT,
        CC_OP,
        CC_ENTER,
        CC_CLR,
        CC_BS
    } char_class_e;

    function automatic char_class_e classify(input logic [7:0] c);
        char_class_e cls;
        cls = CC_OTHER;
        if (c >= ASCII_0 && c <= ASCII_9) begin
            cls = CC_DIGIT;
        end else if (c == ASCII_PLUS || c == ASCII_MINUS ||
                     c == ASCII_STAR || c == ASCII_SLASH) begin
            cls = CC_OP;
        end else if (c == ASCII_CR) begin
            cls = CC_ENTER;
        end else if (c == ASCII_UC_C || c == ASCII_LC_C || c == ASCII_ESC) begin
            cls = CC_CLR;
        end else if (c == ASCII_BS || c == ASCII_DEL) begin
            cls = CC_BS;
        end
        return cls;
    endfunction

    function automatic logic [1:0] op_of(input logic [7:0] c);
        logic [1:0] op;
        case (c)
            ASCII_MINUS: op = OP_SUB;
            ASCII_STAR:  op = OP_MUL;
            ASCII_SLASH: op = OP_DIV;
            default:     op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rx_byte_strobe.sv
// Brings the receiver's byte-ready level into clk, detects its rising edge and captures
// the byte; byte_stb is a one-cycle pulse with rx_byte valid alongside it.
module rx_byte_strobe (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_received,
    output logic       byte_stb,
    output logic [7:0] rx_byte
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       prev_q,  prev_d;
    logic       stb_q,   stb_d;
    logic [7:0] byte_q,  byte_d;
    logic       rise;

    always_comb begin
        rise    = sync2_q & ~prev_q;
        sync1_d = rx_received;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        stb_d   = rise;
        byte_d  = rise ? rx_data : byte_q;
    end

    // Sync/edge flops reset high: a level already high at reset release is not a new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            stb_q   <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            stb_q   <= stb_d;
            byte_q  <= byte_d;
        end
    end

    assign byte_stb = stb_q;
    assign rx_byte  = byte_q;

endmodule

// File: rtl/calc_input_parser.sv
// Parses ASCII keystrokes into BCD operand A, operator, BCD operand B; Enter issues cmd_valid.
// Optional backspace editing is compiled in with CALC_BACKSPACE_EN.
module calc_input_parser
    import calc_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OPW    = 4 * DIGITS
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_received,
    output logic [OPW-1:0] operand_a,
    output logic [OPW-1:0] operand_b,
    output logic [1:0]     op_code,
    output logic           cmd_valid,
    output logic           err,
    output logic [OPW-1:0] cur_display
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic           byte_stb;
    logic [7:0]     rx_byte;
    char_class_e    cls;
    logic [3:0]     digit;

    logic [1:0]     state_q, state_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [CW-1:0]  cnt_a_q, cnt_a_d;
    logic [CW-1:0]  cnt_b_q, cnt_b_d;
    logic [1:0]     op_q, op_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           err_q, err_d;

    rx_byte_strobe u_rx_byte_strobe (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_received (rx_received),
        .byte_stb    (byte_stb),
        .rx_byte     (rx_byte)
    );

    always_comb begin
        cls         = classify(rx_byte);
        digit       = rx_byte[3:0];
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        op_d        = op_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;

        if (byte_stb) begin
            case (cls)
                CC_CLR: begin
                    state_d = ST_ENTER_A;
                    a_d     = '0;
                    b_d     = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    op_d    = OP_ADD;
                end
                CC_DIGIT: begin
                    case (state_q)
                        ST_ENTER_A: begin
                            if (cnt_a_q == CNT_FULL) begin
                                err_d = 1'b1;
                            end else begin
                                a_d     = {a_q[OPW-5:0], digit};
                                cnt_a_d = cnt_a_q + CNT_ONE;
                            end
                        end
                        ST_ENTER_B: begin
                            if (cnt_b_q == CNT_FULL) begin
                                err_d = 1'b1;
                            end else begin
                                b_d     = {b_q[OPW-5:0], digit};
                                cnt_b_d = cnt_b_q + CNT_ONE;
                            end
                        end
                        ST_SHOW: begin
                            // A new digit after a result starts a fresh command.
                            state_d = ST_ENTER_A;
                            a_d     = {{(OPW-4){1'b0}}, digit};
                            b_d     = '0;
                            cnt_a_d = CNT_ONE;
                            cnt_b_d = '0;
                        end
                        default: ;
                    endcase
                end
                CC_OP: begin
                    case (state_q)
                        ST_ENTER_A: begin
                            if (cnt_a_q == '0) begin
                                err_d = 1'b1;
                            end else begin
                                op_d    = op_of(rx_byte);
                                state_d = ST_ENTER_B;
                            end
                        end
                        ST_ENTER_B: begin
                            if (cnt_b_q == '0) begin
                                op_d = op_of(rx_byte);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                CC_ENTER: begin
                    if (state_q == ST_ENTER_B && cnt_b_q != '0) begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_SHOW;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`ifdef CALC_BACKSPACE_EN
                CC_BS: begin
                    case (state_q)
                        ST_ENTER_A: begin
                            if (cnt_a_q != '0) begin
                                a_d     = a_q >> 4;
                                cnt_a_d = cnt_a_q - CNT_ONE;
                            end
                        end
                        ST_ENTER_B: begin
                            if (cnt_b_q != '0) begin
                                b_d     = b_q >> 4;
                                cnt_b_d = cnt_b_q - CNT_ONE;
                            end else begin
                                op_d    = OP_ADD;
                                state_d = ST_ENTER_A;
                            end
                        end
                        default: ;
                    endcase
                end
`else
                CC_BS: ;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            op_q        <= OP_ADD;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            op_q        <= op_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
        end
    end

    assign operand_a   = a_q;
    assign operand_b   = b_q;
    assign op_code     = op_q;
    assign cmd_valid   = cmd_valid_q;
    assign err         = err_q;
    assign cur_display = (state_q == ST_ENTER_A) ? a_q : b_q;

endmodule

// File: tb/tb_calc_input_parser.sv
// Directed bench for calc_input_parser: keystroke sequences with hand-computed results.
module tb_calc_input_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_received;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [1:0]  op_code;
    logic        cmd_valid;
    logic        err;
    logic [15:0] cur_display;

    int total  = 0;
    int passed = 0;
    int cv_cycle = 0;

    calc_input_parser dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_received (rx_received),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .op_code     (op_code),
        .cmd_valid   (cmd_valid),
        .err         (err),
        .cur_display (cur_display)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Counts err/cmd_valid samples over n cycles; records the cycle of the last cmd_valid.
    task automatic watch(input int n, input int drop_at, output int n_err, output int n_cv);
        n_err = 0;
        n_cv  = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (err) n_err++;
            if (cmd_valid) begin
                n_cv++;
                cv_cycle = i;
            end
            check("no_err_and_cv_same_cycle", {31'd0, err & cmd_valid}, 32'd0);
            if (i == drop_at) rx_received = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input int exp_err, input int exp_cv);
        int n_err, n_cv;
        @(negedge clk);
        rx_data     = b;
        rx_received = 1'b1;
        watch(8, 4, n_err, n_cv);
        check($sformatf("err_count_%02h", b), n_err, exp_err);
        check($sformatf("cv_count_%02h", b), n_cv, exp_cv);
        $display("byte %02h: err=%0d cv=%0d a=%04h b=%04h op=%0d disp=%04h",
                 b, n_err, n_cv, operand_a, operand_b, op_code, cur_display);
    endtask

    initial begin
        int n_err, n_cv;
        // Receiver level high with a digit on the bus across reset release.
        reset       = 1'b1;
        rx_data     = 8'h37;
        rx_received = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", operand_a, 0);
        check("reset_b", operand_b, 0);
        check("reset_op", op_code, 0);
        check("reset_cv", cmd_valid, 0);
        check("reset_err", err, 0);
        check("reset_disp", cur_display, 0);
        @(negedge clk);
        reset = 1'b0;
        watch(8, 8, n_err, n_cv);
        check("held_high_err", n_err, 0);
        check("held_high_cv", n_cv, 0);
        check("held_high_a", operand_a, 0);
        repeat (4) @(posedge clk);

        // "12+34\r"
        send(8'h31, 0, 0);
        send(8'h32, 0, 0);
        send(8'h2B, 0, 0);
        check("disp_b_empty", cur_display, 16'h0000);
        send(8'h33, 0, 0);
        check("disp_b_3", cur_display, 16'h0003);
        send(8'h34, 0, 0);
        send(8'h0D, 0, 1);
        check("cv_latency", cv_cycle, 4);
        check("cmd_a", operand_a, 16'h0012);
        check("cmd_b", operand_b, 16'h0034);
        check("cmd_op", op_code, 2'b00);
        check("show_disp", cur_display, 16'h0034);

        // Digit after SHOW starts a new A
        send(8'h39, 0, 0);
        check("new_a", operand_a, 16'h0009);
        check("new_b", operand_b, 16'h0000);
        check("new_disp", cur_display, 16'h0009);

        // Overflow on the fifth digit
        send(8'h63, 0, 0);
        send(8'h31, 0, 0);
        send(8'h32, 0, 0);
        send(8'h33, 0, 0);
        send(8'h34, 0, 0);
        send(8'h35, 1, 0);
        check("ovf_a", operand_a, 16'h1234);
        send(8'h43, 0, 0);
        check("clr_a", operand_a, 16'h0000);

        // Rejected keys
        send(8'h2B, 1, 0);
        send(8'h37, 0, 0);
        check("still_a_disp", cur_display, 16'h0007);
        send(8'h2A, 0, 0);
        check("op_mul", op_code, 2'b10);
        send(8'h0D, 1, 0);
        send(8'h2D, 0, 0);
        check("op_replaced", op_code, 2'b01);
        send(8'h32, 0, 0);
        send(8'h0D, 0, 1);
        check("cmd2_a", operand_a, 16'h0007);
        check("cmd2_b", operand_b, 16'h0002);
        send(8'h2B, 1, 0);
        send(8'h0D, 1, 0);
        check("show_held_op", op_code, 2'b01);

        // Clear mid-entry
        send(8'h34, 0, 0);
        send(8'h2B, 0, 0);
        send(8'h35, 0, 0);
        send(8'h63, 0, 0);
        check("mid_clr_a", operand_a, 0);
        check("mid_clr_b", operand_b, 0);
        check("mid_clr_op", op_code, 0);
        send(8'h38, 0, 0);
        check("after_clr_disp", cur_display, 16'h0008);
        send(8'h78, 0, 0);
        check("other_ignored", operand_a, 16'h0008);

        // Backspace
        send(8'h1B, 0, 0);
        send(8'h35, 0, 0);
        send(8'h36, 0, 0);
        send(8'h08, 0, 0);
`ifdef CALC_BACKSPACE_EN
        check("bs_a", operand_a, 16'h0005);
`else
        check("bs_a", operand_a, 16'h0056);
`endif
        send(8'h63, 0, 0);
        send(8'h35, 0, 0);
        send(8'h2D, 0, 0);
        send(8'h7F, 0, 0);
        send(8'h33, 0, 0);
`ifdef CALC_BACKSPACE_EN
        check("bs_op", op_code, 2'b00);
        check("bs_back_a", operand_a, 16'h0053);
        check("bs_disp", cur_display, 16'h0053);
`else
        check("bs_op", op_code, 2'b01);
        check("bs_back_a", operand_a, 16'h0005);
        check("bs_disp", cur_display, 16'h0003);
`endif

        // Reset one clock after an edge drops the in-flight byte
        send(8'h63, 0, 0);
        @(negedge clk);
        rx_data     = 8'h39;
        rx_received = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        watch(8, 4, n_err, n_cv);
        check("rst_edge_err", n_err, 0);
        check("rst_edge_cv", n_cv, 0);
        check("rst_edge_a", operand_a, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
